// File: rtl/square_seq_ctl_pkg.sv
// Shared constants for the APU square channel sequencer:
// register addresses, duty waveform table, default widths.
package apu_square_pkg;

    localparam int PERIOD_W = 11;
    localparam int MUTE_MIN = 8;

    localparam logic [1:0] SQ_REG_CTRL = 2'd0;
    localparam logic [1:0] SQ_REG_LO   = 2'd2;
    localparam logic [1:0] SQ_REG_HI   = 2'd3;

    // Row = duty mode, bit index = phase (bit 7 = phase 7).
    localparam logic [3:0][7:0] DUTY_TBL = {
        8'b10011111,
        8'b01111000,
        8'b01100000,
        8'b01000000
    };

    function automatic logic duty_bit(
        input logic [1:0] mode,
        input logic [2:0] phase
    );
        return DUTY_TBL[mode][phase];
    endfunction

endpackage

// File: rtl/square_seq_ctl_if.sv
// Register-write bus plus sequencer outputs for one square channel.
// master: CPU/APU side (ACLK_EN, WR, ADDR, DB out; FCO, PHASE, DUTY, MUTE in).
interface square_seq_ctl_if;

    logic       ACLK_EN;
    logic       WR;
    logic [1:0] ADDR;
    logic [7:0] DB;
    logic       FCO;
    logic [2:0] PHASE;
    logic       DUTY;
    logic       MUTE;

    modport master (
        output ACLK_EN, WR, ADDR, DB,
        input  FCO, PHASE, DUTY, MUTE
    );

    modport slave (
        input  ACLK_EN, WR, ADDR, DB,
        output FCO, PHASE, DUTY, MUTE
    );

endinterface

// File: rtl/square_seq_ctl_timer.sv
// square_period_timer: 11-bit down counter with reload and registered carry.
// Ports: CLK, n_RES, i_aclk_en, i_period in; o_fco (registered), o_expire (comb).
// With SQUARE_SEQ_DBG_EN defined, o_cnt exposes the live count.
module square_period_timer #(
    parameter int PERIOD_W = apu_square_pkg::PERIOD_W
) (
    input  logic                CLK,
    input  logic                n_RES,
    input  logic                i_aclk_en,
    input  logic [PERIOD_W-1:0] i_period,
    output logic                o_fco,
    output logic                o_expire
`ifdef SQUARE_SEQ_DBG_EN
    ,
    output logic [PERIOD_W-1:0] o_cnt
`endif
);

    logic [PERIOD_W-1:0] r_cnt;
    logic                r_fco;
    logic                w_expire;

    assign w_expire = i_aclk_en && (r_cnt == '0);

    // Reload takes the period as registered before this edge,
    // so a same-cycle period write only affects the next reload.
    always_ff @(posedge CLK or negedge n_RES) begin
        if (!n_RES) begin
            r_cnt <= '0;
            r_fco <= 1'b0;
        end else begin
            r_fco <= w_expire;
            if (i_aclk_en) begin
                r_cnt <= w_expire ? i_period : r_cnt - 1'b1;
            end
        end
    end

    assign o_fco    = r_fco;
    assign o_expire = w_expire;
`ifdef SQUARE_SEQ_DBG_EN
    assign o_cnt    = r_cnt;
`endif

endmodule

// File: rtl/square_seq_ctl.sv
// Square channel controller: register decode, duty phase, DUTY/MUTE.
// Ports: CLK, n_RES, bus (slave). Macro SQUARE_SEQ_DBG_EN adds DBG_CNT, DBG_PERIOD.
module square_seq_ctl #(
    parameter int PERIOD_W = apu_square_pkg::PERIOD_W,
    parameter int MUTE_MIN = apu_square_pkg::MUTE_MIN
) (
    input  logic              CLK,
    input  logic              n_RES,
    square_seq_ctl_if.slave   bus
`ifdef SQUARE_SEQ_DBG_EN
    ,
    output logic [PERIOD_W-1:0] DBG_CNT,
    output logic [PERIOD_W-1:0] DBG_PERIOD
`endif
);

    import apu_square_pkg::*;

    logic [1:0]          r_duty_mode;
    logic [PERIOD_W-1:0] r_period;
    logic [2:0]          r_phase;

    logic w_wr_ctrl;
    logic w_wr_lo;
    logic w_wr_hi;
    logic w_expire;
    logic w_fco;

    assign w_wr_ctrl = bus.WR && (bus.ADDR == SQ_REG_CTRL);
    assign w_wr_lo   = bus.WR && (bus.ADDR == SQ_REG_LO);
    assign w_wr_hi   = bus.WR && (bus.ADDR == SQ_REG_HI);

    square_period_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .CLK       (CLK),
        .n_RES     (n_RES),
        .i_aclk_en (bus.ACLK_EN),
        .i_period  (r_period),
        .o_fco     (w_fco),
        .o_expire  (w_expire)
`ifdef SQUARE_SEQ_DBG_EN
        ,
        .o_cnt     (DBG_CNT)
`endif
    );

    // A high-byte write restarts the sequence at phase 0 and
    // overrides a decrement from a coincident expiry.
    always_ff @(posedge CLK or negedge n_RES) begin
        if (!n_RES) begin
            r_duty_mode <= 2'd0;
            r_period    <= '0;
            r_phase     <= 3'd0;
        end else begin
            if (w_wr_ctrl) begin
                r_duty_mode <= bus.DB[7:6];
            end
            if (w_wr_lo) begin
                r_period[7:0] <= bus.DB;
            end
            if (w_wr_hi) begin
                r_period[PERIOD_W-1:8] <= bus.DB[PERIOD_W-9:0];
            end
            if (w_wr_hi) begin
                r_phase <= 3'd0;
            end else if (w_expire) begin
                r_phase <= r_phase - 3'd1;
            end
        end
    end

    assign bus.FCO   = w_fco;
    assign bus.PHASE = r_phase;
    assign bus.DUTY  = duty_bit(r_duty_mode, r_phase);
    assign bus.MUTE  = (r_period < PERIOD_W'(MUTE_MIN));

`ifdef SQUARE_SEQ_DBG_EN
    assign DBG_PERIOD = r_period;
`endif

endmodule
